// File: rtl/afifo_rd_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port among NUM_REQ read-domain consumers.
// Define AFIFO_RD_ARB_BURST_EN to let a winner hold the port for up to MAX_BURST pops.
module afifo_rd_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       rempty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rinc,
  input  logic [NUM_REQ-1:0]         req,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_vld,
  output logic [$clog2(NUM_REQ)-1:0] dout_id,
  output logic                       busy
);

  localparam int unsigned IdW     = $clog2(NUM_REQ);
  localparam logic [IdW:0] NumReqW = NUM_REQ[IdW:0];

  if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
    $error("afifo_rd_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StServe, StLock} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [IdW-1:0]        dout_id_q, dout_id_d;
  logic                  dout_vld_q, dout_vld_d;

`ifdef AFIFO_RD_ARB_BURST_EN
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  logic [IdW-1:0]  owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic           fire;
  logic           found;
  logic [IdW-1:0] winner;
  logic [IdW:0]   scan_idx;

  function automatic logic [IdW-1:0] next_ptr(input logic [IdW-1:0] p);
    return (p == IdW'(NUM_REQ - 1)) ? '0 : p + IdW'(1);
  endfunction

  // First set request scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr_q} + (IdW + 1)'(i);
      if (scan_idx >= NumReqW) scan_idx = scan_idx - NumReqW;
      if (!found && req[scan_idx[IdW-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IdW-1:0];
      end
    end
  end

  always_comb begin
    fire       = (|req) && !rempty && !rrst;
    rinc       = 1'b0;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    dout_d     = dout_q;
    dout_id_d  = dout_id_q;
    dout_vld_d = 1'b0;
`ifdef AFIFO_RD_ARB_BURST_EN
    owner_d    = owner_q;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      StIdle, StServe: begin
        if (fire) begin
          rinc       = 1'b1;
          dout_d     = rdata;
          dout_id_d  = winner;
          dout_vld_d = 1'b1;
          rr_ptr_d   = next_ptr(winner);
          state_d    = StServe;
`ifdef AFIFO_RD_ARB_BURST_EN
          // A one-pop burst is indistinguishable from plain arbitration.
          if (MAX_BURST > 1) begin
            state_d = StLock;
            owner_d = winner;
            cnt_d   = CntW'(1);
          end
`endif
        end else begin
          state_d = StIdle;
        end
      end
`ifdef AFIFO_RD_ARB_BURST_EN
      StLock: begin
        if (req[owner_q] && !rempty && !rrst) begin
          rinc       = 1'b1;
          dout_d     = rdata;
          dout_id_d  = owner_q;
          dout_vld_d = 1'b1;
          cnt_d      = cnt_q + CntW'(1);
          if (32'(cnt_q) + 32'd1 == MAX_BURST) begin
            state_d  = StServe;
            rr_ptr_d = next_ptr(owner_q);
          end
        end else begin
          state_d  = StServe;
          rr_ptr_d = next_ptr(owner_q);
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      dout_q     <= '0;
      dout_id_q  <= '0;
      dout_vld_q <= 1'b0;
`ifdef AFIFO_RD_ARB_BURST_EN
      owner_q    <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      dout_q     <= dout_d;
      dout_id_q  <= dout_id_d;
      dout_vld_q <= dout_vld_d;
`ifdef AFIFO_RD_ARB_BURST_EN
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign dout     = dout_q;
  assign dout_id  = dout_id_q;
  assign dout_vld = dout_vld_q;
  assign busy     = (state_q != StIdle);

endmodule
